adc_seq: RTL and testbench

ADC_SEQ -- requirements
Module: adc_seq

---
 rtl/adc_seq.sv | 196 +++++++++++++++++++
 tb/tb_adc_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq.sv
// Scan sequencer for a multiplexed SAR ADC: settles the mux, pulses conversions and keeps per-channel results.
// Optional ADC_SEQ_THRESH_EN adds a sticky out-of-window interrupt on captured samples.
module adc_seq #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DW      = 10,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cfg_en,
    input  logic                   cfg_cont,
    input  logic [NCH-1:0]         cfg_mask,
    input  logic                   start,
    output logic [$clog2(NCH)-1:0] adc_sel,
    output logic                   adc_start,
    input  logic                   adc_done,
    input  logic [DW-1:0]          adc_data,
    output logic [NCH*DW-1:0]      res_data,
    output logic [NCH-1:0]         res_valid,
    input  logic [NCH-1:0]         res_clr,
`ifdef ADC_SEQ_THRESH_EN
    input  logic [DW-1:0]          thr_hi,
    input  logic [DW-1:0]          thr_lo,
    output logic                   thr_irq,
`endif
    output logic                   busy,
    output logic                   scan_done,
    output logic                   timeout_err
);

    localparam int unsigned SW           = $clog2(NCH);
    localparam int unsigned CW           = 16;
    localparam int unsigned SETTLE_LAST  = (SETTLE == 0) ? 0 : SETTLE - 1;
    localparam int unsigned TIMEOUT_LAST = TIMEOUT - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_CONV   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [SW-1:0]            sel_q, sel_d;
    logic [NCH-1:0]           scan_mask_q, scan_mask_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     adc_start_q, adc_start_d;
    logic                     busy_q, busy_d;
    logic                     scan_done_q, scan_done_d;
    logic                     terr_q, terr_d;
    logic [NCH-1:0][DW-1:0]   data_q, data_d;
    logic [NCH-1:0]           valid_q, valid_d;
    logic [NCH-1:0]           rem_c;
    logic                     accept_c;
    logic                     capture_c;

    function automatic logic [SW-1:0] first_set(input logic [NCH-1:0] m);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (m[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // scan_mask holds the channels still to convert in the current scan
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        scan_mask_d = scan_mask_q;
        cnt_d       = cnt_q;
        adc_start_d = 1'b0;
        scan_done_d = 1'b0;
        terr_d      = terr_q;
        data_d      = data_q;
        valid_d     = valid_q & ~res_clr;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        rem_c       = scan_mask_q & ~(NCH'(1) << sel_q);

        if ((state_q != S_IDLE) && !cfg_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && cfg_en && (cfg_mask != '0)) begin
                        accept_c    = 1'b1;
                        terr_d      = 1'b0;
                        scan_mask_d = cfg_mask;
                        sel_d       = first_set(cfg_mask);
                        cnt_d       = '0;
                        state_d     = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(SETTLE_LAST)) begin
                        cnt_d       = '0;
                        adc_start_d = 1'b1;
                        state_d     = S_CONV;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_CONV: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (adc_done) begin
                        capture_c      = 1'b1;
                        data_d[sel_q]  = adc_data;
                        valid_d[sel_q] = 1'b1;
                        state_d        = S_STORE;
                    end else if (cnt_q == CW'(TIMEOUT_LAST)) begin
                        terr_d  = 1'b1;
                        state_d = S_STORE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STORE: begin
                    scan_mask_d = rem_c;
                    cnt_d       = '0;
                    if (rem_c != '0) begin
                        sel_d   = first_set(rem_c);
                        state_d = S_SETTLE;
                    end else begin
                        scan_done_d = 1'b1;
                        if (cfg_cont && (cfg_mask != '0)) begin
                            scan_mask_d = cfg_mask;
                            sel_d       = first_set(cfg_mask);
                            state_d     = S_SETTLE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            scan_mask_q <= '0;
            cnt_q       <= '0;
            adc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            terr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            scan_mask_q <= scan_mask_d;
            cnt_q       <= cnt_d;
            adc_start_q <= adc_start_d;
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
            terr_q      <= terr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign adc_sel     = sel_q;
    assign adc_start   = adc_start_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = terr_q;
    assign res_data    = data_q;
    assign res_valid   = valid_q;

`ifdef ADC_SEQ_THRESH_EN
    logic thr_q, thr_d;

    // Window check on each captured sample; an accepted start clears the flag
    always_comb begin
        thr_d = thr_q;
        if (accept_c) thr_d = 1'b0;
        if (capture_c && ((adc_data > thr_hi) || (adc_data < thr_lo))) thr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) thr_q <= 1'b0;
        else         thr_q <= thr_d;
    end

    assign thr_irq = thr_q;
`endif

endmodule

// File: tb/tb_adc_seq.sv
// Scoreboard bench for adc_seq: queued expected channel order and scan completions,
// checked by a monitor against a per-channel result model fed by an ADC responder.
module tb_adc_seq;
    localparam int unsigned NCH = 4;
    localparam int unsigned DW = 10;

    logic clk = 1'b0, resetn = 1'b0, cfg_en = 1'b0, cfg_cont = 1'b0, start = 1'b0;
    logic [NCH-1:0] cfg_mask = '0, clr_m = '0, clr_r = '0, res_clr, res_valid;
    logic [1:0] adc_sel;
    logic adc_start, busy, scan_done, timeout_err, adc_done;
    logic done_r = 1'b0, done_m = 1'b0;
    logic [DW-1:0] data_r = '0, data_m = '0, adc_data;
    logic [NCH*DW-1:0] res_data;
`ifdef ADC_SEQ_THRESH_EN
    logic [DW-1:0] thr_hi = 10'h300, thr_lo = 10'h010;
    logic thr_irq;
`endif

    assign adc_done = done_r | done_m;
    assign adc_data = data_r | data_m;
    assign res_clr  = clr_m | clr_r;

    adc_seq #(.NCH(NCH), .DW(DW), .SETTLE(2), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .cfg_en(cfg_en), .cfg_cont(cfg_cont),
        .cfg_mask(cfg_mask), .start(start), .adc_sel(adc_sel), .adc_start(adc_start),
        .adc_done(adc_done), .adc_data(adc_data), .res_data(res_data),
        .res_valid(res_valid), .res_clr(res_clr),
`ifdef ADC_SEQ_THRESH_EN
        .thr_hi(thr_hi), .thr_lo(thr_lo), .thr_irq(thr_irq),
`endif
        .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] mdl_data [NCH];
    logic [DW-1:0] adc_val [NCH];
    logic [NCH-1:0] mdl_valid = '0;
    logic mdl_terr = 1'b0, mdl_thr = 1'b0;
    int exp_ch[$];
    int pend_done = 0;
    int model_ch = 0;
    int tmo_ch = -1, clr_ch = -1, fixed_lat = 0;
    bit resp_en = 1'b1;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [NCH*DW-1:0] exp_res();
        logic [NCH*DW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NCH); i++) v[i*DW +: DW] = mdl_data[i];
        return v;
    endfunction

    // Monitor: every conversion start and scan completion is checked against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && adc_start) begin
                if (exp_ch.size() == 0) chk("adc_start_unexpected", 64'(adc_start), 64'(0));
                else begin
                    model_ch = exp_ch.pop_front();
                    chk("adc_sel", 64'(adc_sel), 64'(model_ch));
                end
            end
            if (resetn && scan_done) begin
                if (pend_done == 0) chk("scan_done_unexpected", 64'(scan_done), 64'(0));
                else begin
                    pend_done--;
                    chk("res_data", 64'(res_data), 64'(exp_res()));
                    chk("res_valid", 64'(res_valid), 64'(mdl_valid));
                    chk("timeout_err", 64'(timeout_err), 64'(mdl_terr));
`ifdef ADC_SEQ_THRESH_EN
                    chk("thr_irq", 64'(thr_irq), 64'(mdl_thr));
`endif
                end
            end
        end
    end

    // ADC responder: answers each conversion after a latency and updates the model
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && resetn && adc_start) begin
                int lat;
                int ch;
                lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
                repeat (lat) @(negedge clk);
                ch = model_ch;
                if (ch == tmo_ch) begin
                    mdl_terr = 1'b1;
                end else begin
                    done_r = 1'b1;
                    data_r = adc_val[ch];
                    mdl_data[ch] = adc_val[ch];
                    mdl_valid[ch] = 1'b1;
                    if (adc_val[ch] > 10'h300 || adc_val[ch] < 10'h010) mdl_thr = 1'b1;
                    if (ch == clr_ch) clr_r[ch] = 1'b1;
                    @(negedge clk);
                    done_r = 1'b0;
                    data_r = '0;
                    clr_r = '0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m);
        cfg_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_scan(input logic [NCH-1:0] m);
        for (int i = 0; i < int'(NCH); i++) if (m[i]) exp_ch.push_back(i);
        pend_done++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((pend_done != 0 || exp_ch.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending_done"}, 64'(pend_done), 64'(0));
        tick(2);
        chk({name, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    task automatic do_scan(input string name, input logic [NCH-1:0] m);
        push_scan(m);
        mdl_terr = 1'b0;
        mdl_thr = 1'b0;
        pulse_start(m);
        @(negedge clk);
        chk({name, "_busy"}, 64'(busy), 64'(1));
        chk({name, "_terr_cleared"}, 64'(timeout_err), 64'(0));
`ifdef ADC_SEQ_THRESH_EN
        chk({name, "_thr_cleared"}, 64'(thr_irq), 64'(0));
`endif
        wait_idle(name);
    endtask

    initial begin
        int cyc, n_done, busy_low;
        logic [NCH-1:0] m;
        for (int i = 0; i < int'(NCH); i++) begin
            mdl_data[i] = '0;
            adc_val[i] = '0;
        end
        tick(2);
        chk("rst_sel", 64'(adc_sel), 64'(0));
        chk("rst_start", 64'(adc_start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(scan_done), 64'(0));
        chk("rst_terr", 64'(timeout_err), 64'(0));
        chk("rst_valid", 64'(res_valid), 64'(0));
        chk("rst_data", 64'(res_data), 64'(0));
        resetn = 1'b1;
        cfg_en = 1'b1;
        tick(2);

        // Ignored starts: empty mask, then disabled sequencer
        pulse_start('0);
        tick(1);
        chk("mask0_busy", 64'(busy), 64'(0));
        tick(6);
        chk("mask0_busy_late", 64'(busy), 64'(0));
        cfg_en = 1'b0;
        pulse_start(4'b1111);
        tick(1);
        chk("en0_busy", 64'(busy), 64'(0));
        tick(6);
        cfg_en = 1'b1;

        // Stray adc_done while idle
        done_m = 1'b1;
        data_m = 10'h3FF;
        tick(1);
        done_m = 1'b0;
        data_m = '0;
        tick(1);
        chk("stray_done_valid", 64'(res_valid), 64'(mdl_valid));
        chk("stray_done_data", 64'(res_data), 64'(exp_res()));

        // Single scan of channels 1 and 3, with a start and mask change while busy
        fixed_lat = 3;
        adc_val[1] = 10'h155;
        adc_val[3] = 10'h2AA;
        push_scan(4'b1010);
        mdl_terr = 1'b0;
        mdl_thr = 1'b0;
        pulse_start(4'b1010);
        tick(3);
        cfg_mask = 4'b0101;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("single");
        chk("single_valid", 64'(res_valid), 64'(4'b1010));
        chk("single_ch1", 64'(res_data[1*DW +: DW]), 64'(10'h155));
        chk("single_ch3", 64'(res_data[3*DW +: DW]), 64'(10'h2AA));
        fixed_lat = 0;

        clr_m = 4'b1111;
        tick(1);
        clr_m = '0;
        mdl_valid = '0;
        chk("idle_clear", 64'(res_valid), 64'(0));

        clr_ch = 2;
        adc_val[2] = 10'h0C3;
        do_scan("clr_coinc", 4'b0100);
        chk("clr_coinc_valid2", 64'(res_valid[2]), 64'(1));
        clr_ch = -1;

        for (int k = 0; k < 6; k++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < int'(NCH); i++) adc_val[i] = 10'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                clr_m = 4'($urandom);
                tick(1);
                mdl_valid = mdl_valid & ~clr_m;
                clr_m = '0;
            end
            do_scan("random", m);
        end

        // Channel 0 never answers
        clr_m = 4'b0001;
        tick(1);
        clr_m = '0;
        mdl_valid[0] = 1'b0;
        tmo_ch = 0;
        adc_val[1] = 10'h111;
        do_scan("timeout", 4'b0011);
        chk("timeout_flag", 64'(timeout_err), 64'(1));
        chk("timeout_valid0", 64'(res_valid[0]), 64'(0));
        chk("timeout_ch1", 64'(res_data[1*DW +: DW]), 64'(10'h111));
        tmo_ch = -1;
        do_scan("timeout_clr", 4'b0001);

`ifdef ADC_SEQ_THRESH_EN
        adc_val[0] = 10'h005;
        do_scan("thr_low", 4'b0001);
        chk("thr_set", 64'(thr_irq), 64'(1));
        adc_val[0] = 10'h100;
        do_scan("thr_clr", 4'b0001);
`endif

        // Continuous scan of channel 0, then disable mid-scan
        cfg_cont = 1'b1;
        adc_val[0] = 10'($urandom);
        push_scan(4'b0001);
        push_scan(4'b0001);
        push_scan(4'b0001);
        mdl_terr = 1'b0;
        mdl_thr = 1'b0;
        pulse_start(4'b0001);
        n_done = 0;
        busy_low = 0;
        cyc = 0;
        while (n_done < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_low++;
            if (scan_done) n_done++;
        end
        cfg_en = 1'b0;
        cfg_cont = 1'b0;
        chk("cont_scans", 64'(n_done), 64'(3));
        chk("cont_busy_low", 64'(busy_low), 64'(0));
        tick(1);
        chk("cont_abort_busy", 64'(busy), 64'(0));
        chk("cont_abort_start", 64'(adc_start), 64'(0));
        tick(10);
        cfg_en = 1'b1;

        // Abort while settling channel 1; channel 0 result retained
        adc_val[0] = 10'h0AB;
        exp_ch.push_back(0);
        pulse_start(4'b0011);
        cyc = 0;
        while (!(busy && adc_sel == 2'd1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_ch1", 64'(adc_sel), 64'(1));
        cfg_en = 1'b0;
        tick(1);
        chk("abort_busy", 64'(busy), 64'(0));
        tick(10);
        chk("abort_data", 64'(res_data), 64'(exp_res()));
        chk("abort_valid", 64'(res_valid), 64'(mdl_valid));
        cfg_en = 1'b1;

        // Reset during WAIT, then a late adc_done
        resp_en = 1'b0;
        exp_ch.push_back(0);
        pulse_start(4'b0001);
        cyc = 0;
        while (!adc_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_wait_start", 64'(adc_start), 64'(1));
        tick(1);
        #1 resetn = 1'b0;
        #1;
        for (int i = 0; i < int'(NCH); i++) mdl_data[i] = '0;
        mdl_valid = '0;
        chk("midrst_sel", 64'(adc_sel), 64'(0));
        chk("midrst_start", 64'(adc_start), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(scan_done), 64'(0));
        chk("midrst_terr", 64'(timeout_err), 64'(0));
        chk("midrst_valid", 64'(res_valid), 64'(0));
        chk("midrst_data", 64'(res_data), 64'(0));
        tick(1);
        resetn = 1'b1;
        tick(1);
        done_m = 1'b1;
        data_m = 10'h2AA;
        tick(1);
        done_m = 1'b0;
        data_m = '0;
        tick(2);
        chk("late_done_valid", 64'(res_valid), 64'(0));
        chk("late_done_data", 64'(res_data), 64'(0));
        chk("late_done_busy", 64'(busy), 64'(0));
        chk("queue_empty", 64'(exp_ch.size()), 64'(0));
        chk("pending_done", 64'(pend_done), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
